// File: rtl/waveform_sequencer.sv
// Note-table sequencer that drives waveform_player's configuration port (period, play enable).
// Define SEQ_IRQ_EN to add an end-of-sequence interrupt output (irq) with STATUS clear.
module waveform_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic        p_address,
    output logic        p_write,
    output logic [31:0] p_writedata,
`ifdef SEQ_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [5:0]    LEN_MAX   = 6'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PERIOD, S_ENABLE, S_HOLD, S_ADVANCE, S_STOP} state_t;

    state_t        r_state;
    logic [31:0]   r_table [DEPTH];
    logic [5:0]    r_length;
    logic          r_loop;
    logic [4:0]    r_index;
    logic [15:0]   r_period;
    logic [15:0]   r_duration;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_ticks;
    logic          r_busy;
    logic          r_p_address;
    logic          r_p_write;
    logic [31:0]   r_p_writedata;
    logic [31:0]   r_readdata;
    logic          w_irq_bit;

    logic          w_wr_ctrl, w_wr_len, w_ent_sel, w_wr_ent;
    logic [IW-1:0] w_ent_addr;
    logic [5:0]    w_index_p1;
    logic          w_more, w_wrap, w_start, w_abort, w_load, w_enter_stop;
    logic [4:0]    w_next_idx;
    logic [31:0]   w_entry;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_mux;

    assign w_wr_ctrl  = s_write && (s_address == 6'h00);
    assign w_wr_len   = s_write && (s_address == 6'h02);
    assign w_ent_sel  = s_address[5] && ({1'b0, s_address[4:0]} < LEN_MAX);
    assign w_wr_ent   = s_write && w_ent_sel;
    assign w_ent_addr = s_address[IW-1:0];

    // End check uses the live LENGTH so shortening it mid-run ends (or wraps) at the next ADVANCE
    assign w_index_p1   = {1'b0, r_index} + 6'd1;
    assign w_more       = w_index_p1 < r_length;
    assign w_wrap       = r_loop && (r_length != 6'd0);
    assign w_start      = w_wr_ctrl && s_writedata[0] && !s_writedata[1]
                          && (r_state == S_IDLE) && (r_length != 6'd0);
    assign w_abort      = w_wr_ctrl && s_writedata[1] && (r_state != S_IDLE) && (r_state != S_STOP);
    assign w_load       = w_start || ((r_state == S_ADVANCE) && (w_more || w_wrap));
    assign w_next_idx   = ((r_state == S_ADVANCE) && w_more) ? w_index_p1[4:0] : 5'd0;
    assign w_entry      = r_table[w_next_idx[IW-1:0]];
    assign w_enter_stop = w_abort || ((r_state == S_ADVANCE) && !w_load);

    assign w_status = {19'd0, r_index, 5'd0, r_loop, w_irq_bit, r_busy};

    always_comb begin
        w_rd_mux = 32'd0;
        if (s_address == 6'h01)
            w_rd_mux = w_status;
        else if (s_address == 6'h02)
            w_rd_mux = {26'd0, r_length};
        else if (w_ent_sel)
            w_rd_mux = r_table[w_ent_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= 32'd0;
            r_length   <= 6'd0;
            r_loop     <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            if (w_wr_ent)
                r_table[w_ent_addr] <= s_writedata;
            if (w_wr_len)
                r_length <= (s_writedata[5:0] > LEN_MAX) ? LEN_MAX : s_writedata[5:0];
            if (w_wr_ctrl)
                r_loop <= s_writedata[2];
            r_readdata <= s_read ? w_rd_mux : 32'd0;
        end
    end

    // Outputs are registered, so the write for a state is set up on the edge that enters it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_index       <= 5'd0;
            r_period      <= 16'd0;
            r_duration    <= 16'd0;
            r_presc       <= '0;
            r_ticks       <= 16'd0;
            r_busy        <= 1'b0;
            r_p_address   <= 1'b0;
            r_p_write     <= 1'b0;
            r_p_writedata <= 32'd0;
        end else begin
            r_p_write <= 1'b0;
            if (w_abort || w_enter_stop) begin
                r_state       <= S_STOP;
                r_p_write     <= 1'b1;
                r_p_address   <= 1'b1;
                r_p_writedata <= 32'd0;
            end else if (w_load) begin
                r_busy     <= 1'b1;
                r_index    <= w_next_idx;
                r_period   <= w_entry[31:16];
                r_duration <= w_entry[15:0];
                if (w_entry[15:0] == 16'd0) begin
                    r_state <= S_ADVANCE;
                end else begin
                    r_state       <= S_PERIOD;
                    r_p_write     <= 1'b1;
                    r_p_address   <= (w_entry[31:16] == 16'd0);
                    r_p_writedata <= {16'd0, w_entry[31:16]};
                end
            end else begin
                case (r_state)
                    S_PERIOD: begin
                        r_state       <= S_ENABLE;
                        r_p_write     <= 1'b1;
                        r_p_address   <= 1'b1;
                        r_p_writedata <= {31'd0, (r_period != 16'd0)};
                    end
                    S_ENABLE: begin
                        r_state <= S_HOLD;
                        r_presc <= PRESC_TOP;
                        r_ticks <= r_duration - 16'd1;
                    end
                    S_HOLD: begin
                        if (r_presc == '0) begin
                            r_presc <= PRESC_TOP;
                            if (r_ticks == 16'd0)
                                r_state <= S_ADVANCE;
                            else
                                r_ticks <= r_ticks - 16'd1;
                        end else begin
                            r_presc <= r_presc - 1'b1;
                        end
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

`ifdef SEQ_IRQ_EN
    logic r_irq;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_irq <= 1'b0;
        else if (w_enter_stop)
            r_irq <= 1'b1;
        else if (s_write && (s_address == 6'h01) && s_writedata[0])
            r_irq <= 1'b0;
    end
    assign irq       = r_irq;
    assign w_irq_bit = r_irq;
`else
    assign w_irq_bit = 1'b0;
`endif

    assign s_readdata  = r_readdata;
    assign p_address   = r_p_address;
    assign p_write     = r_p_write;
    assign p_writedata = r_p_writedata;
    assign busy        = r_busy;
endmodule
